data_memory_hs: RTL and testbench

//  Parametrised word-organised data memory for the single-cycle/multi-cycle MIPS datapath.

---
 rtl/data_memory_pkg.sv | 19 +
 rtl/mem_lane_align.sv | 50 +++++
 rtl/data_memory_hs.sv | 125 ++++++++++++
 tb/tb_data_memory_hs.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared definitions for the handshaked MIPS data memory: access size codes,
// response FSM states and the default byte-lane count.
package data_memory_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  localparam int DATA_W_DEF = 32;
  localparam int BYTE_LANES = DATA_W_DEF / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte enables and data replication,
// load lane extraction with zero or sign extension.
module mem_lane_align
  import data_memory_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          size_i,
  input  logic                signed_i,
  input  logic [1:0]          lane_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W/8-1:0] be_o,
  output logic [DATA_W-1:0]   wdata_o,
  input  logic [DATA_W-1:0]   rword_i,
  output logic [DATA_W-1:0]   rdata_o
);
  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] shifted;

  // Replicating the narrow value across all lanes lets the byte enables alone pick the target.
  always_comb begin
    be_o    = '0;
    wdata_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = LANES'(1) << lane_i;
        wdata_o = {LANES{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = LANES'(3) << {lane_i[1], 1'b0};
        wdata_o = {(LANES/2){wdata_i[15:0]}};
      end
      SZ_WORD: be_o = '1;
      default: be_o = '0;
    endcase
  end

  assign shifted = rword_i >> {lane_i, 3'b000};

  always_comb begin
    rdata_o = shifted;
    case (size_i)
      SZ_BYTE: rdata_o = {{(DATA_W-8){signed_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_o = {{(DATA_W-16){signed_i & shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_memory_hs.sv
// Windowed byte/half/word data memory with valid/ready request and response
// channels, fixed response latency and a single outstanding transaction.
module data_memory_hs
  import data_memory_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0040_0000,
  parameter int                LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANES = DATA_W / 8;
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [ADDR_W-1:0] off;
  logic              in_win;
  logic              misaligned;
  logic              acc_err;
  logic              accept;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [LANES-1:0]  st_be;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] ld_data;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  // The lower-bound test keeps addresses below the window from wrapping into it.
  assign off        = req_addr_i - BASE_ADDR;
  assign in_win     = (req_addr_i >= BASE_ADDR) && ({2'b00, off[ADDR_W-1:2]} < ADDR_W'(DEPTH));
  assign misaligned = ((req_size_i == SZ_HALF) && off[0]) ||
                      ((req_size_i == SZ_WORD) && (off[1:0] != 2'b00));
  assign acc_err    = !in_win || misaligned || (req_size_i == SZ_BAD);
  assign idx        = off[IDX_W+1:2];
  assign accept     = req_valid_i && req_ready_o;

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size_i   (req_size_i),
    .signed_i (req_signed_i),
    .lane_i   (off[1:0]),
    .wdata_i  (req_wdata_i),
    .be_o     (st_be),
    .wdata_o  (st_data),
    .rword_i  (mem_q[idx]),
    .rdata_o  (ld_data)
  );

  // Array has no reset so a store committed before a reset survives it.
  always_ff @(posedge clk) begin
    if (accept && req_we_i && !acc_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (st_be[i]) mem_q[idx][i*8 +: 8] <= st_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The counter starts at 1 because the accept cycle counts toward the latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d   = acc_err;
          rdata_d = (acc_err || req_we_i) ? '0 : ld_data;
          cnt_d   = (LATENCY > 1) ? CNT_W'(1) : '0;
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Drives a LATENCY=1 and a LATENCY=3 instance in lockstep against a byte-array reference model.
`timescale 1ns/1ps
module tb_data_memory_hs;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_we, req_signed, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rdy1, vld1, err1, rdy3, vld3, err3;
  logic [31:0] rd1, rd3;

  data_memory_hs #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy1), .req_we_i(req_we),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(vld1), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd1), .rsp_err_o(err1));

  data_memory_hs #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy3), .req_we_i(req_we),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(vld3), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd3), .rsp_err_o(err3));

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  mbytes [4*DEPTH];
  logic [31:0] last_rd;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat little-endian byte array addressed by byte offset.
  task automatic model_txn(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] erd, output logic eerr);
    int          n, off;
    logic [31:0] v;
    eerr = 1'b0;
    erd  = '0;
    if (addr < BASE || (addr - BASE) >= 32'(4*DEPTH)) eerr = 1'b1;
    if (sz == 2'b11) eerr = 1'b1;
    else if (sz == 2'b01 && addr[0]) eerr = 1'b1;
    else if (sz == 2'b10 && addr[1:0] != 2'b00) eerr = 1'b1;
    if (!eerr) begin
      n   = 1 << sz;
      off = int'(addr - BASE);
      if (we) begin
        for (int k = 0; k < n; k++) mbytes[off+k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mbytes[off+k];
        if (sg && n < 4 && v[8*n-1]) begin
          for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        end
        erd = v;
      end
    end
  endtask

  task automatic do_txn(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold);
    logic [31:0] erd;
    logic        eerr;
    int          c, lat1, lat3;
    bit          s1, s3;
    model_txn(we, sz, sg, addr, wd, erd, eerr);
    checkb({tag, ":req_ready1"}, rdy1, 1'b1);
    checkb({tag, ":req_ready3"}, rdy3, 1'b1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd; rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_we = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    c = 1; lat1 = 0; lat3 = 0; s1 = 0; s3 = 0;
    while (!(s1 && s3) && c <= 12) begin
      if (!s1 && vld1) begin
        s1 = 1; lat1 = c;
        check({tag, ":rdata1"}, rd1, erd);
        checkb({tag, ":err1"}, err1, eerr);
      end
      if (!s3 && vld3) begin
        s3 = 1; lat3 = c;
        check({tag, ":rdata3"}, rd3, erd);
        checkb({tag, ":err3"}, err3, eerr);
        last_rd = rd3; last_err = err3;
      end
      if (!(s1 && s3)) begin
        @(posedge clk); #1;
        c++;
      end
    end
    check({tag, ":latency1"}, lat1, 1);
    check({tag, ":latency3"}, lat3, 3);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
      req_addr = BASE + 8; req_wdata = $urandom;
      checkb({tag, ":hold_vld1"}, vld1, 1'b1);
      checkb({tag, ":hold_vld3"}, vld3, 1'b1);
      check({tag, ":hold_rd1"}, rd1, erd);
      check({tag, ":hold_rd3"}, rd3, erd);
      checkb({tag, ":hold_err3"}, err3, eerr);
      checkb({tag, ":hold_rdy1"}, rdy1, 1'b0);
      checkb({tag, ":hold_rdy3"}, rdy3, 1'b0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkb({tag, ":done_vld1"}, vld1, 1'b0);
    checkb({tag, ":done_vld3"}, vld3, 1'b0);
    $display("txn %s we=%0b size=%0d signed=%0b addr=0x%08h rdata=0x%08h err=%0b",
             tag, we, sz, sg, addr, last_rd, last_err);
  endtask

  logic [31:0] a, wd, erd;
  logic [1:0]  s;
  logic        eerr;

  initial begin
    for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkb("reset:vld1", vld1, 1'b0);
    checkb("reset:vld3", vld3, 1'b0);
    check("reset:rdata1", rd1, 32'h0);
    checkb("reset:err3", err3, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn("sw_base", 1, 2'b10, 0, BASE, 32'h00EAF820, 0);
    do_txn("lw_base", 0, 2'b10, 0, BASE, 32'h0, 0);
    check("lw_base:value", last_rd, 32'h00EAF820);
    do_txn("sw_b4", 1, 2'b10, 0, BASE + 4, 32'h8FF3AAAA, 0);
    do_txn("lb_b7", 0, 2'b00, 1, BASE + 7, 32'h0, 0);
    check("lb_b7:value", last_rd, 32'hFFFFFF8F);
    do_txn("lbu_b7", 0, 2'b00, 0, BASE + 7, 32'h0, 0);
    check("lbu_b7:value", last_rd, 32'h0000008F);
    do_txn("lh_b4", 0, 2'b01, 1, BASE + 4, 32'h0, 0);
    check("lh_b4:value", last_rd, 32'hFFFFAAAA);
    do_txn("sb_b5", 1, 2'b00, 0, BASE + 5, 32'h00000011, 0);
    do_txn("lw_b4", 0, 2'b10, 0, BASE + 4, 32'h0, 0);
    check("lw_b4:value", last_rd, 32'h8FF311AA);

    do_txn("lw_below", 0, 2'b10, 0, 32'h003FFFFC, 32'h0, 0);
    checkb("lw_below:err", last_err, 1'b1);
    do_txn("lw_above", 0, 2'b10, 0, BASE + 4*DEPTH, 32'h0, 0);
    checkb("lw_above:err", last_err, 1'b1);
    do_txn("lw_b4_again", 0, 2'b10, 0, BASE + 4, 32'h0, 0);
    check("lw_b4_again:value", last_rd, 32'h8FF311AA);
    do_txn("lw_mis", 0, 2'b10, 0, BASE + 2, 32'h0, 0);
    do_txn("lh_mis", 0, 2'b01, 1, BASE + 1, 32'h0, 0);
    do_txn("lsz11", 0, 2'b11, 0, BASE, 32'h0, 0);
    checkb("lsz11:err", last_err, 1'b1);
    do_txn("sw_mis", 1, 2'b10, 0, BASE + 2, 32'hFFFFFFFF, 0);
    do_txn("sh_mis", 1, 2'b01, 0, BASE + 1, 32'h0000FFFF, 0);
    do_txn("ssz11", 1, 2'b11, 0, BASE, 32'hFFFFFFFF, 0);
    do_txn("lw_base_kept", 0, 2'b10, 0, BASE, 32'h0, 0);
    check("lw_base_kept:value", last_rd, 32'h00EAF820);

    do_txn("sw_b8", 1, 2'b10, 0, BASE + 8, 32'h12345678, 0);
    do_txn("lw_hold", 0, 2'b10, 0, BASE + 8, 32'h0, 5);
    do_txn("lw_b8", 0, 2'b10, 0, BASE + 8, 32'h0, 0);
    check("lw_b8:value", last_rd, 32'h12345678);

    // Reset while the LATENCY=3 instance is still counting a store.
    wd = 32'hC0FFEE42;
    model_txn(1, 2'b10, 0, BASE + 12, wd, erd, eerr);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = BASE + 12; req_wdata = wd; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkb("rst_mid:pre_vld1", vld1, 1'b1);
    checkb("rst_mid:pre_vld3", vld3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkb("rst_mid:vld1", vld1, 1'b0);
    checkb("rst_mid:vld3", vld3, 1'b0);
    checkb("rst_mid:rdy3", rdy3, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkb("rst_mid:dropped_vld3", vld3, 1'b0);
    end
    $display("txn rst_mid sw addr=0x%08h wdata=0x%08h reset during wait", BASE + 12, wd);
    do_txn("lw_b12", 0, 2'b10, 0, BASE + 12, 32'h0, 0);
    check("lw_b12:value", last_rd, 32'hC0FFEE42);

    for (int i = 0; i < DEPTH; i++) do_txn("fill", 1, 2'b10, 0, BASE + 32'(4*i), $urandom, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) s = 2'b11;
      else s = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'($urandom_range(1, 8));
        1:       a = BASE + 32'(4*DEPTH) + 32'($urandom_range(0, 8));
        default: a = BASE + 32'($urandom_range(0, 4*DEPTH - 1));
      endcase
      if (s != 2'b11 && $urandom_range(0, 1) == 1) a = a & ~((32'd1 << s) - 32'd1);
      do_txn("rnd", 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
